uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_tx.sv | 82 ++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state type and default oversample rate for uart_tx and uart_rx.
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;
  localparam int OVERSAMPLE_DEFAULT = 16;
endpackage

// File: rtl/uart_tx.sv
// uart_tx: frames parallel words into a serial line (start, LSB-first data, optional parity, stop).
module uart_tx
  import uart_pkg::*;
#(
  parameter int DataWidth      = 8,
  parameter int OverSampleRate = OVERSAMPLE_DEFAULT,
  parameter bit ParityEn       = 1'b0,
  parameter bit ParityOdd      = 1'b0,
  parameter int StopBits       = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tick_i,
  input  logic                 tx_valid_i,
  input  logic [DataWidth-1:0] data_i,
  output logic                 tx_ready_o,
  output logic                 tx_o,
  output logic                 tx_busy_o,
  output logic                 tx_done_o
);
  localparam int CW = $clog2(OverSampleRate);
  localparam int BW = $clog2(DataWidth);
  tx_state_e state, state_n;
  logic [CW-1:0] tick_cnt, tick_cnt_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic [DataWidth-1:0] shreg, shreg_n;
  logic par, par_n, tx_n, done_n, bit_end;
  assign tx_ready_o = state == IDLE;
  assign tx_busy_o  = ~tx_ready_o;
  assign bit_end    = tick_i && tick_cnt == CW'(OverSampleRate - 1);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      tx_o      <= 1'b1;
      tx_done_o <= 1'b0;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      par       <= par_n;
      tx_o      <= tx_n;
      tx_done_o <= done_n;
    end
  end
  always_comb begin
    state_n    = state;
    tick_cnt_n = (state != IDLE && tick_i) ? (bit_end ? '0 : tick_cnt + 1'b1) : tick_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    par_n      = par;
    done_n     = 1'b0;
    case (state)
      IDLE: if (tx_valid_i) begin
        state_n    = START;
        shreg_n    = data_i;
        par_n      = ^data_i ^ ParityOdd;
        tick_cnt_n = '0;
        bit_cnt_n  = '0;
      end
      START: if (bit_end) state_n = DATA;
      DATA: if (bit_end) begin
        shreg_n   = shreg >> 1;
        bit_cnt_n = bit_cnt == BW'(DataWidth - 1) ? '0 : bit_cnt + 1'b1;
        state_n   = bit_cnt != BW'(DataWidth - 1) ? DATA : ParityEn ? PARITY : STOP;
      end
      PARITY: if (bit_end) state_n = STOP;
      STOP: if (bit_end) begin
        done_n    = bit_cnt == BW'(StopBits - 1);
        state_n   = done_n ? IDLE : STOP;
        bit_cnt_n = done_n ? '0 : bit_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
    // line level follows the state being entered so tx_o stays aligned with state
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shreg_n[0] : state_n == PARITY ? par_n : 1'b1;
  end
endmodule
